// File: rtl/caf_sweep_pkg.sv
// Shared definitions for the frequency-sweep arg-max controller: state encoding
// and default sweep geometry.
package caf_sweep_pkg;

  localparam int NUM_BINS_DEF = 8;
  localparam int BIN_BITS_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_OUT  = 2'b11
  } sweep_state_e;

endpackage

// File: rtl/sweep_best_tracker.sv
// Running best-peak register for a sweep: keeps the largest per-bin peak seen,
// with the first bin always taken and ties resolved toward the earlier bin.
module sweep_best_tracker #(
  parameter int BIN_BITS     = 3,
  parameter int INDEX_BITS   = 4,
  parameter int OUT_MAX_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  input  logic                    i_capture,
  input  logic                    i_first,
  input  logic [BIN_BITS-1:0]     i_bin,
  input  logic [OUT_MAX_BITS-1:0] i_am_max,
  input  logic [INDEX_BITS-1:0]   i_am_index,
  output logic [OUT_MAX_BITS-1:0] o_nxt_max,
  output logic [BIN_BITS-1:0]     o_best_bin,
  output logic [INDEX_BITS-1:0]   o_best_index,
  output logic [OUT_MAX_BITS-1:0] o_best_max
);

  logic [BIN_BITS-1:0]     r_best_bin;
  logic [INDEX_BITS-1:0]   r_best_index;
  logic [OUT_MAX_BITS-1:0] r_best_max;
  logic                    w_take;

  // Strict greater-than keeps the lower bin on ties.
  assign w_take    = i_capture && (i_first || (i_am_max > r_best_max));
  assign o_nxt_max = w_take ? i_am_max : r_best_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_bin   <= '0;
      r_best_index <= '0;
      r_best_max   <= '0;
    end else if (i_clear) begin
      r_best_bin   <= '0;
      r_best_index <= '0;
      r_best_max   <= '0;
    end else if (w_take) begin
      r_best_bin   <= i_bin;
      r_best_index <= i_am_index;
      r_best_max   <= i_am_max;
    end
  end

  assign o_best_bin   = r_best_bin;
  assign o_best_index = r_best_index;
  assign o_best_max   = r_best_max;

endmodule

// File: rtl/argmax_sweep_ctrl.sv
// Steps a frequency shifter through NUM_BINS bins, collects one arg-max result
// per bin and reports the overall peak. Define ARGMAX_SWEEP_THRESH_EN to add the
// thresh input and registered res_detect output.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | freq_load pulse, shifter retunes to freq_bin
// RUN   | am_ready high, waiting for the arg-max result of this bin
// OUT   | res_valid high, holding result until res_ready
module argmax_sweep_ctrl
  import caf_sweep_pkg::*;
#(
  parameter int NUM_BINS     = NUM_BINS_DEF,
  parameter int BIN_BITS     = BIN_BITS_DEF,
  parameter int INDEX_BITS   = 4,
  parameter int OUT_MAX_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic [BIN_BITS-1:0]     freq_bin,
  output logic                    freq_load,
  input  logic                    am_valid,
  input  logic [OUT_MAX_BITS-1:0] am_max,
  input  logic [INDEX_BITS-1:0]   am_index,
  output logic                    am_ready,
`ifdef ARGMAX_SWEEP_THRESH_EN
  input  logic [OUT_MAX_BITS-1:0] thresh,
  output logic                    res_detect,
`endif
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [BIN_BITS-1:0]     res_bin,
  output logic [INDEX_BITS-1:0]   res_index,
  output logic [OUT_MAX_BITS-1:0] res_max
);

  localparam logic [BIN_BITS-1:0] LAST_BIN = BIN_BITS'(NUM_BINS - 1);

  sweep_state_e            r_state;
  logic [BIN_BITS-1:0]     r_bin;
  logic                    r_busy;
  logic                    r_freq_load;
  logic                    r_am_ready;
  logic                    r_res_valid;
  logic                    w_clear;
  logic                    w_capture;
  logic                    w_last;
  logic [OUT_MAX_BITS-1:0] w_nxt_max;

  assign w_clear   = (r_state == ST_IDLE) && start;
  assign w_capture = (r_state == ST_RUN) && am_valid;
  assign w_last    = (r_bin == LAST_BIN);

  sweep_best_tracker #(
    .BIN_BITS     (BIN_BITS),
    .INDEX_BITS   (INDEX_BITS),
    .OUT_MAX_BITS (OUT_MAX_BITS)
  ) u_best (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_capture    (w_capture),
    .i_first      (r_bin == '0),
    .i_bin        (r_bin),
    .i_am_max     (am_max),
    .i_am_index   (am_index),
    .o_nxt_max    (w_nxt_max),
    .o_best_bin   (res_bin),
    .o_best_index (res_index),
    .o_best_max   (res_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bin       <= '0;
      r_busy      <= 1'b0;
      r_freq_load <= 1'b0;
      r_am_ready  <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_freq_load <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_LOAD;
            r_bin       <= '0;
            r_busy      <= 1'b1;
            r_freq_load <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state    <= ST_RUN;
          r_am_ready <= 1'b1;
        end
        ST_RUN: begin
          if (am_valid) begin
            r_am_ready <= 1'b0;
            if (w_last) begin
              r_state     <= ST_OUT;
              r_res_valid <= 1'b1;
            end else begin
              r_state     <= ST_LOAD;
              r_bin       <= r_bin + BIN_BITS'(1);
              r_freq_load <= 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARGMAX_SWEEP_THRESH_EN
  logic r_res_detect;

  // Evaluated on the final capture so it lands together with res_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_detect <= 1'b0;
    end else if (w_capture && w_last) begin
      r_res_detect <= (w_nxt_max >= thresh);
    end
  end

  assign res_detect = r_res_detect;
`endif

  assign busy      = r_busy;
  assign freq_bin  = r_bin;
  assign freq_load = r_freq_load;
  assign am_ready  = r_am_ready;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_argmax_sweep_ctrl.sv
// Randomized self-checking bench for argmax_sweep_ctrl: a 4-bin instance driven
// by a responder, checked against a plain arg-max model, plus a 1-bin instance.
module tb_argmax_sweep_ctrl;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic [1:0] freq_bin;
  logic       freq_load;
  logic       am_valid = 1'b0;
  logic [3:0] am_max = '0;
  logic [3:0] am_index = '0;
  logic       am_ready;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [1:0] res_bin;
  logic [3:0] res_index;
  logic [3:0] res_max;

  logic       s1_start = 1'b0;
  logic       s1_busy;
  logic [0:0] s1_freq_bin;
  logic       s1_freq_load;
  logic       s1_am_valid = 1'b0;
  logic [3:0] s1_am_max = '0;
  logic [3:0] s1_am_index = '0;
  logic       s1_am_ready;
  logic       s1_res_valid;
  logic       s1_res_ready = 1'b0;
  logic [0:0] s1_res_bin;
  logic [3:0] s1_res_index;
  logic [3:0] s1_res_max;

`ifdef ARGMAX_SWEEP_THRESH_EN
  logic [3:0] thresh = '0;
  logic       res_detect;
  logic [3:0] s1_thresh = '0;
  logic       s1_res_detect;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cycle_cnt = 0;
  int m_max [NB];
  int m_idx [NB];

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  argmax_sweep_ctrl #(.NUM_BINS(NB), .BIN_BITS(2), .INDEX_BITS(4), .OUT_MAX_BITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .freq_bin(freq_bin), .freq_load(freq_load),
    .am_valid(am_valid), .am_max(am_max), .am_index(am_index), .am_ready(am_ready),
`ifdef ARGMAX_SWEEP_THRESH_EN
    .thresh(thresh), .res_detect(res_detect),
`endif
    .res_valid(res_valid), .res_ready(res_ready),
    .res_bin(res_bin), .res_index(res_index), .res_max(res_max)
  );

  argmax_sweep_ctrl #(.NUM_BINS(1), .BIN_BITS(1), .INDEX_BITS(4), .OUT_MAX_BITS(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .busy(s1_busy),
    .freq_bin(s1_freq_bin), .freq_load(s1_freq_load),
    .am_valid(s1_am_valid), .am_max(s1_am_max), .am_index(s1_am_index), .am_ready(s1_am_ready),
`ifdef ARGMAX_SWEEP_THRESH_EN
    .thresh(s1_thresh), .res_detect(s1_res_detect),
`endif
    .res_valid(s1_res_valid), .res_ready(s1_res_ready),
    .res_bin(s1_res_bin), .res_index(s1_res_index), .res_max(s1_res_max)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full sweep; abort_bin >= 0 pulses reset while that bin is in RUN.
  task automatic do_sweep(input int k, input bit noise, input int stall, input int abort_bin);
    int bb, exp_bin, cur, wcnt, guard, t0;
    bit aborted;
    logic [31:0] exp_res;
    bb = 0;
    for (int i = 1; i < NB; i++) if (m_max[i] > m_max[bb]) bb = i;
    exp_res = {19'd0, 1'b1, 2'(bb), 4'(m_idx[bb]), 4'(m_max[bb])};
    @(negedge clk);
    start = 1'b1;
    t0 = cycle_cnt;
    exp_bin = 0; cur = 0; wcnt = 0; guard = 0; aborted = 1'b0;
    while (!res_valid && guard < 400 && !aborted) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      am_valid = 1'b0;
      if (freq_load) begin
        chk("bin_seq", 32'(freq_bin), 32'(exp_bin));
        exp_bin++;
      end
      if (am_ready) begin
        if (cur == abort_bin) begin
          rst_n = 1'b0;
          #1;
          chk("reset_outputs",
              {20'd0, busy, freq_load, am_ready, res_valid, freq_bin, res_bin, res_index, res_max}, 0);
          aborted = 1'b1;
        end else if (wcnt == k) begin
          am_valid = 1'b1;
          am_max   = 4'(m_max[cur]);
          am_index = 4'(m_idx[cur]);
          cur++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else if (noise) begin
        start    = 1'($urandom % 2);
        am_valid = 1'($urandom % 2);
        am_max   = 4'd15;
        am_index = 4'($urandom);
      end
    end
    start = 1'b0;
    am_valid = 1'b0;
    if (aborted) begin
      bit seen;
      seen = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (res_valid || busy) seen = 1'b1;
      end
      chk("no_result_after_abort", 32'(seen), 0);
      return;
    end
    chk("sweep_done", 32'(res_valid), 1);
    chk("bin_loads", 32'(exp_bin), NB);
    chk("latency", 32'(cycle_cnt - t0), 32'(NB * (k + 2) + 1));
    chk("res_bin", 32'(res_bin), 32'(bb));
    chk("res_index", 32'(res_index), 32'(m_idx[bb]));
    chk("res_max", 32'(res_max), 32'(m_max[bb]));
`ifdef ARGMAX_SWEEP_THRESH_EN
    chk("res_detect", 32'(res_detect), 32'(m_max[bb] >= int'(thresh)));
`endif
    repeat (stall) begin
      @(negedge clk);
      chk("hold_stable", {19'd0, res_valid, res_bin, res_index, res_max}, exp_res);
    end
    res_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    chk("idle_after_ready", {30'd0, busy, res_valid}, 0);
    @(negedge clk);
    chk("start_at_handshake_ignored", {30'd0, busy, freq_load}, 0);
  endtask

  initial begin
    int g, t0;
    bit sent;
    #1;
    chk("reset_state",
        {20'd0, busy, freq_load, am_ready, res_valid, freq_bin, res_bin, res_index, res_max}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    m_max = '{3, 9, 5, 2}; m_idx = '{1, 7, 2, 0};
`ifdef ARGMAX_SWEEP_THRESH_EN
    thresh = 4'd9;
`endif
    do_sweep(0, 1'b0, 0, -1);
`ifdef ARGMAX_SWEEP_THRESH_EN
    thresh = 4'd10;
`endif
    do_sweep(2, 1'b0, 20, -1);

    m_max = '{6, 6, 6, 6}; m_idx = '{11, 3, 4, 5};
    do_sweep(1, 1'b1, 0, -1);

    m_max = '{1, 4, 8, 15}; m_idx = '{9, 8, 7, 6};
    do_sweep(1, 1'b0, 0, 2);
    do_sweep(0, 1'b0, 1, -1);

    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < NB; i++) begin
        m_max[i] = int'($urandom_range(0, 15));
        m_idx[i] = int'($urandom_range(0, 15));
      end
`ifdef ARGMAX_SWEEP_THRESH_EN
      thresh = 4'($urandom);
`endif
      do_sweep(int'($urandom_range(0, 3)), 1'($urandom % 2), int'($urandom_range(0, 3)), -1);
    end

    @(negedge clk);
    s1_start = 1'b1;
    t0 = cycle_cnt;
    g = 0;
    sent = 1'b0;
    while (!s1_res_valid && g < 50) begin
      @(negedge clk);
      g++;
      s1_start = 1'b0;
      s1_am_valid = 1'b0;
      if (s1_am_ready && !sent) begin
        s1_am_valid = 1'b1;
        s1_am_max = 4'd11;
        s1_am_index = 4'd5;
        sent = 1'b1;
      end
    end
    s1_am_valid = 1'b0;
    chk("one_bin_done", 32'(s1_res_valid), 1);
    chk("one_bin_latency", 32'(cycle_cnt - t0), 3);
    chk("one_bin_res", {22'd0, s1_res_bin, s1_res_index, s1_res_max}, {22'd0, 1'b0, 4'd5, 4'd11});
    s1_res_ready = 1'b1;
    @(negedge clk);
    s1_res_ready = 1'b0;
    chk("one_bin_idle", {30'd0, s1_busy, s1_res_valid}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
